writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 133 +++++++++++++
 tb/tb_writeback_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges in-order pipeline writes with a one-entry
// buffered multi-cycle (MDU) result onto a single registered RF write port.
// Ports: clk_i, rst_i (async, active-high)
//   pipe_write_i / pipe_stall_o : pipeline write request and stall
//   mdu_valid_i, mdu_rd_address_i, mdu_data_i / mdu_ready_o : MDU handshake
//   mdu_pending_o : buffered MDU result waiting
//   write_o : registered register-file write
package wb_pkg;
  typedef logic [4:0] register_t;
  typedef struct packed {
    logic      write_enable;
    register_t rd_address;
    logic [31:0] data;
  } register_file_write_t;
endpackage

module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  register_file_write_t pipe_write_i,
  output logic                 pipe_stall_o,
  input  logic                 mdu_valid_i,
  input  register_t            mdu_rd_address_i,
  input  logic [31:0]          mdu_data_i,
  output logic                 mdu_ready_o,
  output logic                 mdu_pending_o,
  output register_file_write_t write_o
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HELD   = 2'd1,
    FORCED = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_count;
  register_t   buf_addr;
  logic [31:0] buf_data;

  logic pipe_req;
  logic grant_pipe;
  logic grant_buf;
  logic load_buf;

  // rd == 0 is a non-request: it can neither win nor be stalled
  assign pipe_req = pipe_write_i.write_enable &&
                    (pipe_write_i.rd_address != '0);

  assign load_buf = (state == EMPTY) && mdu_valid_i &&
                    (mdu_rd_address_i != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: begin
        if (load_buf) state_next = HELD;
      end
      HELD: begin
        if (!pipe_req) state_next = EMPTY;
        else if (wait_count + 4'd1 == LIMIT) state_next = FORCED;
      end
      FORCED: state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    grant_pipe    = 1'b0;
    grant_buf     = 1'b0;
    mdu_ready_o   = (state == EMPTY);
    mdu_pending_o = (state != EMPTY);
    unique case (state)
      EMPTY: grant_pipe = pipe_req;
      HELD: begin
        grant_pipe = pipe_req;
        grant_buf  = !pipe_req;
      end
      FORCED: grant_buf = 1'b1;
      default: ;
    endcase
    pipe_stall_o = pipe_req && grant_buf;
  end

  // Starvation counter only advances while the buffer loses to the pipe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_count <= '0;
    end else if (state_next == EMPTY || load_buf) begin
      wait_count <= '0;
    end else if (state == HELD && pipe_req) begin
      wait_count <= wait_count + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_addr <= '0;
      buf_data <= '0;
    end else if (load_buf) begin
      buf_addr <= mdu_rd_address_i;
      buf_data <= mdu_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_o <= '0;
    end else if (grant_pipe) begin
      write_o <= '{1'b1, pipe_write_i.rd_address, pipe_write_i.data};
    end else if (grant_buf) begin
      write_o <= '{1'b1, buf_addr, buf_data};
    end else begin
      write_o <= '0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed scenarios followed by
// constrained-random traffic against an abstract arbitration model.
module tb_writeback_arbiter;
  import wb_pkg::*;

  localparam int LIM = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  register_file_write_t pipe_write = '0;
  logic                 pipe_stall;
  logic                 mdu_valid = 1'b0;
  register_t            mdu_rd = '0;
  logic [31:0]          mdu_data = '0;
  logic                 mdu_ready;
  logic                 mdu_pending;
  register_file_write_t write;

  int vectors = 0;
  int miscompares = 0;

  register_file_write_t exp_q[$];

  // abstract model: an optional buffered result and how often it lost
  bit          m_buf = 0;
  register_t   m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_loss = 0;

  bit last_stall = 0;
  bit mdu_hold = 0;

  writeback_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pipe_write_i(pipe_write),
    .pipe_stall_o(pipe_stall),
    .mdu_valid_i(mdu_valid),
    .mdu_rd_address_i(mdu_rd),
    .mdu_data_i(mdu_data),
    .mdu_ready_o(mdu_ready),
    .mdu_pending_o(mdu_pending),
    .write_o(write)
  );

  always #5 clk = ~clk;

  function automatic bit preq();
    return pipe_write.write_enable && pipe_write.rd_address != 0;
  endfunction

  function automatic bit buf_wins();
    return m_buf && (m_loss >= LIM || !preq());
  endfunction

  task automatic chk(input string name, input logic [37:0] act,
                     input logic [37:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req,
               $time);
    end
  endtask

  task automatic check_comb();
    chk("pipe_stall", 38'(pipe_stall), 38'(preq() && buf_wins()));
    chk("mdu_ready", 38'(mdu_ready), 38'(!m_buf));
    chk("mdu_pending", 38'(mdu_pending), 38'(m_buf));
  endtask

  task automatic model_edge();
    register_file_write_t e;
    bit bw, acc;
    e = '0;
    if (rst) begin
      m_buf = 0;
      m_loss = 0;
      last_stall = 0;
      mdu_hold = 0;
    end else begin
      bw = buf_wins();
      acc = mdu_valid && !m_buf;
      last_stall = preq() && bw;
      mdu_hold = mdu_valid && !acc;
      if (bw) begin
        e = '{1'b1, m_addr, m_data};
        m_buf = 0;
        m_loss = 0;
      end else if (preq()) begin
        e = '{1'b1, pipe_write.rd_address, pipe_write.data};
        if (m_buf) m_loss++;
      end
      if (acc && mdu_rd != 0) begin
        m_buf = 1;
        m_addr = mdu_rd;
        m_data = mdu_data;
        m_loss = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic pwe, input register_t prd,
                      input logic [31:0] pd, input logic mv,
                      input register_t mrd, input logic [31:0] md);
    @(negedge clk);
    pipe_write = '{pwe, prd, pd};
    mdu_valid = mv;
    mdu_rd = mrd;
    mdu_data = md;
    #4;
    check_comb();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    pipe_write = '0;
    mdu_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_write", 38'(write), 38'(0));
    m_buf = 0;
    m_loss = 0;
    check_comb();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // monitor: every edge yields exactly one expected write
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk("write_o", write, exp_q.pop_front());
  end

  initial begin
    register_file_write_t pw;
    logic mv;
    register_t mr;
    logic [31:0] md;
    #1;
    chk("rst_write", 38'(write), 38'(0));
    check_comb();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0;

    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 7, 32'h12345678);
    idle(3);
    step(0, 0, 0, 1, 9, 32'h9999_0009);
    for (int i = 0; i < 8; i++) step(1, 3, 32'h0000_0333, 0, 0, 0);
    idle(2);
    step(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hAAAA_AAAA);
    idle(2);
    step(0, 0, 0, 1, 9, 32'h9999_0009);
    reset_pulse();
    idle(6);
    step(1, 6, 32'h0000_0666, 1, 4, 32'h0000_0444);
    idle(3);

    pw = '0; mv = 0; mr = '0; md = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) reset_pulse();
      if (!last_stall) begin
        pw.write_enable = ($urandom_range(0, 9) < 7);
        pw.rd_address = ($urandom_range(0, 7) == 0) ? 5'd0
                        : register_t'($urandom);
        pw.data = $urandom;
      end
      if (!mdu_hold) begin
        mv = ($urandom_range(0, 3) == 0);
        mr = ($urandom_range(0, 7) == 0) ? 5'd0 : register_t'($urandom);
        md = $urandom;
      end
      step(pw.write_enable, pw.rd_address, pw.data, mv, mr, md);
    end
    idle(4);

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
